// File: rtl/n_tap_complex_fir_stream_if.sv
// Streaming complex FIR bus: coefficient load handshake, sample input,
// flush request, status flags and filtered output.
//   master : sample/coefficient source (drives loadCoeff, coeffValid,
//            coeffInRe/Im, dataInValid, dataInRe/Im, flush)
//   slave  : the filter (drives coeffReady, coeffSetFlag, busy,
//            dataOutValid, dataOutRe/Im)
interface n_tap_complex_fir_stream_if #(
  parameter int LENGTH      = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int OUT_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 1 + $clog2(LENGTH)
);
  logic                          loadCoeff;
  logic                          coeffValid;
  logic signed [COEFF_WIDTH-1:0] coeffInRe;
  logic signed [COEFF_WIDTH-1:0] coeffInIm;
  logic                          coeffReady;
  logic                          coeffSetFlag;
  logic                          dataInValid;
  logic signed [DATA_WIDTH-1:0]  dataInRe;
  logic signed [DATA_WIDTH-1:0]  dataInIm;
  logic                          flush;
  logic                          busy;
  logic                          dataOutValid;
  logic signed [OUT_WIDTH-1:0]   dataOutRe;
  logic signed [OUT_WIDTH-1:0]   dataOutIm;

  modport master (
    output loadCoeff, coeffValid, coeffInRe, coeffInIm,
    output dataInValid, dataInRe, dataInIm, flush,
    input  coeffReady, coeffSetFlag, busy, dataOutValid, dataOutRe, dataOutIm
  );

  modport slave (
    input  loadCoeff, coeffValid, coeffInRe, coeffInIm,
    input  dataInValid, dataInRe, dataInIm, flush,
    output coeffReady, coeffSetFlag, busy, dataOutValid, dataOutRe, dataOutIm
  );
endinterface

// File: rtl/n_tap_complex_fir_stream.sv
// Streaming complex FIR, y[n] = sum_k h[k]*x[n-k], full precision.
// Ports:
//   clock  : rising-edge system clock
//   resetN : asynchronous active-low reset
//   bus    : n_tap_complex_fir_stream_if.slave (coefficient load, samples,
//            flush, status flags, filtered output)
// Pipeline: delay-line shift -> per-tap complex products -> adder tree/output.
// A sample accepted on edge N is presented on the output after edge N+2.
module n_tap_complex_fir_stream #(
  parameter int LENGTH      = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int OUT_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 1 + $clog2(LENGTH)
) (
  input logic                         clock,
  input logic                         resetN,
  n_tap_complex_fir_stream_if.slave   bus
);
  localparam int PW = DATA_WIDTH + COEFF_WIDTH + 1;
  localparam int IW = $clog2(LENGTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]                    r_state;
  logic [IW-1:0]                 r_idx;
  logic [IW-1:0]                 r_flushCnt;
  logic signed [COEFF_WIDTH-1:0] r_hRe [LENGTH];
  logic signed [COEFF_WIDTH-1:0] r_hIm [LENGTH];
  logic signed [DATA_WIDTH-1:0]  r_xRe [LENGTH];
  logic signed [DATA_WIDTH-1:0]  r_xIm [LENGTH];
  logic signed [PW-1:0]          r_pRe [LENGTH];
  logic signed [PW-1:0]          r_pIm [LENGTH];
  logic [2:0]                    r_vldPipe;   // [0] shifted, [1] products, [2] output
  logic signed [OUT_WIDTH-1:0]   r_outRe;
  logic signed [OUT_WIDTH-1:0]   r_outIm;

  logic                          w_load;
  logic                          w_accept;
  logic                          w_inject;
  logic                          w_shift;
  logic                          w_coeffWr;
  logic signed [DATA_WIDTH-1:0]  w_inRe;
  logic signed [DATA_WIDTH-1:0]  w_inIm;
  logic signed [PW-1:0]          w_prodRe [LENGTH];
  logic signed [PW-1:0]          w_prodIm [LENGTH];
  logic signed [OUT_WIDTH-1:0]   w_sumRe;
  logic signed [OUT_WIDTH-1:0]   w_sumIm;

  // loadCoeff wins over data/flush in READY and is ignored only during FLUSH.
  assign w_load    = bus.loadCoeff && (r_state != S_FLUSH);
  assign w_accept  = (r_state == S_READY) && !bus.loadCoeff && bus.dataInValid;
  assign w_inject  = (r_state == S_FLUSH);
  assign w_shift   = w_accept || w_inject;
  assign w_coeffWr = (r_state == S_LOAD) && !bus.loadCoeff && bus.coeffValid;
  assign w_inRe    = w_inject ? '0 : bus.dataInRe;
  assign w_inIm    = w_inject ? '0 : bus.dataInIm;

  // Operands are widened before multiplying so each product and the
  // re/im difference or sum are exact.
  always_comb begin
    for (int k = 0; k < LENGTH; k++) begin
      w_prodRe[k] = PW'(r_hRe[k]) * PW'(r_xRe[k]) - PW'(r_hIm[k]) * PW'(r_xIm[k]);
      w_prodIm[k] = PW'(r_hRe[k]) * PW'(r_xIm[k]) + PW'(r_hIm[k]) * PW'(r_xRe[k]);
    end
  end

  always_comb begin
    w_sumRe = '0;
    w_sumIm = '0;
    for (int k = 0; k < LENGTH; k++) begin
      w_sumRe = w_sumRe + OUT_WIDTH'(r_pRe[k]);
      w_sumIm = w_sumIm + OUT_WIDTH'(r_pIm[k]);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_flushCnt <= '0;
      r_vldPipe  <= '0;
      r_outRe    <= '0;
      r_outIm    <= '0;
      for (int k = 0; k < LENGTH; k++) begin
        r_hRe[k] <= '0;
        r_hIm[k] <= '0;
        r_xRe[k] <= '0;
        r_xIm[k] <= '0;
        r_pRe[k] <= '0;
        r_pIm[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE:  if (bus.loadCoeff) r_state <= S_LOAD;
        S_LOAD:  if (w_coeffWr && r_idx == IW'(LENGTH - 1)) r_state <= S_READY;
        S_READY: begin
          if (bus.loadCoeff)  r_state <= S_LOAD;
          else if (bus.flush) r_state <= S_FLUSH;
        end
        default: if (r_flushCnt == IW'(LENGTH - 2)) r_state <= S_READY;
      endcase

      if (w_load)         r_idx <= '0;
      else if (w_coeffWr) r_idx <= r_idx + 1'b1;

      if (w_coeffWr) begin
        r_hRe[r_idx] <= bus.coeffInRe;
        r_hIm[r_idx] <= bus.coeffInIm;
      end

      if (r_state == S_READY && !bus.loadCoeff && bus.flush) r_flushCnt <= '0;
      else if (w_inject)                                     r_flushCnt <= r_flushCnt + 1'b1;

      // Delay line: index 0 holds the newest sample, x[n-k] sits at k.
      if (w_load) begin
        for (int k = 0; k < LENGTH; k++) begin
          r_xRe[k] <= '0;
          r_xIm[k] <= '0;
        end
      end else if (w_shift) begin
        r_xRe[0] <= w_inRe;
        r_xIm[0] <= w_inIm;
        for (int k = 1; k < LENGTH; k++) begin
          r_xRe[k] <= r_xRe[k-1];
          r_xIm[k] <= r_xIm[k-1];
        end
      end

      // The product stage always sees the pre-clear delay line, so samples
      // already in flight when a reload starts finish with the old taps.
      r_vldPipe <= {r_vldPipe[1:0], w_shift};

      if (r_vldPipe[0]) begin
        for (int k = 0; k < LENGTH; k++) begin
          r_pRe[k] <= w_prodRe[k];
          r_pIm[k] <= w_prodIm[k];
        end
      end

      if (r_vldPipe[1]) begin
        r_outRe <= w_sumRe;
        r_outIm <= w_sumIm;
      end
    end
  end

  assign bus.coeffReady   = (r_state == S_LOAD);
  assign bus.coeffSetFlag = (r_state == S_READY) || (r_state == S_FLUSH);
  assign bus.busy         = (r_state == S_LOAD) || (r_state == S_FLUSH);
  assign bus.dataOutValid = r_vldPipe[2];
  assign bus.dataOutRe    = r_outRe;
  assign bus.dataOutIm    = r_outIm;
endmodule

// File: tb/tb_n_tap_complex_fir_stream.sv
module tb_n_tap_complex_fir_stream;
  localparam int L  = 12;
  localparam int DW = 8;
  localparam int CW = 8;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;
  localparam int M_FLUSH = 3;

  logic clock = 1'b0;
  logic resetN;
  always #5 clock = ~clock;

  n_tap_complex_fir_stream_if #(.LENGTH(L), .DATA_WIDTH(DW), .COEFF_WIDTH(CW)) bus ();

  n_tap_complex_fir_stream #(.LENGTH(L), .DATA_WIDTH(DW), .COEFF_WIDTH(CW)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  int passes = 0;
  int total  = 0;

  // reference model: filter state, taps, sample history (newest first),
  // and a two-deep queue of results waiting for the output
  int     ms, midx, mrem;
  longint hRe [L];
  longint hIm [L];
  longint xqr [$];
  longint xqi [$];
  longint nre, nim;
  bit     d1v, d2v;
  longint d1re, d1im, d2re, d2im, lastRe, lastIm;

  // observation helpers
  longint capRe [$];
  longint capIm [$];
  int     busyCnt;
  longint tRe [L];
  longint tIm [L];

  task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic void m_clear_hist();
    xqr.delete();
    xqi.delete();
  endfunction

  function automatic void m_reset();
    ms = M_IDLE; midx = 0; mrem = 0;
    for (int k = 0; k < L; k++) begin hRe[k] = 0; hIm[k] = 0; end
    m_clear_hist();
    d1v = 0; d2v = 0; d1re = 0; d1im = 0; d2re = 0; d2im = 0;
    lastRe = 0; lastIm = 0;
  endfunction

  // push a sample into the history and compute the full convolution sum
  function automatic void m_push(longint re, longint im);
    xqr.push_front(re);
    xqi.push_front(im);
    if (xqr.size() > L) begin
      void'(xqr.pop_back());
      void'(xqi.pop_back());
    end
    nre = 0; nim = 0;
    for (int k = 0; k < xqr.size(); k++) begin
      nre += hRe[k] * xqr[k] - hIm[k] * xqi[k];
      nim += hRe[k] * xqi[k] + hIm[k] * xqr[k];
    end
  endfunction

  task automatic check_outputs_zero(string tag);
    check({tag, ".coeffReady"},   bus.coeffReady,   0);
    check({tag, ".coeffSetFlag"}, bus.coeffSetFlag, 0);
    check({tag, ".busy"},         bus.busy,         0);
    check({tag, ".dataOutValid"}, bus.dataOutValid, 0);
    check({tag, ".dataOutRe"},    bus.dataOutRe,    0);
    check({tag, ".dataOutIm"},    bus.dataOutIm,    0);
  endtask

  // one clock: drive inputs, step the model on the edge, compare after it
  task automatic cyc(bit lc, bit cv, longint cre, longint cim,
                     bit dv, longint dre, longint dim, bit fl);
    bit nv;
    bit ev;
    bus.loadCoeff   = lc;
    bus.coeffValid  = cv;
    bus.coeffInRe   = CW'(cre);
    bus.coeffInIm   = CW'(cim);
    bus.dataInValid = dv;
    bus.dataInRe    = DW'(dre);
    bus.dataInIm    = DW'(dim);
    bus.flush       = fl;
    @(posedge clock);
    #1;
    nv = 0; nre = 0; nim = 0;
    case (ms)
      M_IDLE: if (lc) begin ms = M_LOAD; midx = 0; m_clear_hist(); end
      M_LOAD: begin
        if (lc) begin midx = 0; m_clear_hist(); end
        else if (cv) begin
          hRe[midx] = cre; hIm[midx] = cim; midx++;
          if (midx == L) ms = M_READY;
        end
      end
      M_READY: begin
        if (lc) begin ms = M_LOAD; midx = 0; m_clear_hist(); end
        else begin
          if (dv) begin m_push(dre, dim); nv = 1; end
          if (fl) begin ms = M_FLUSH; mrem = L - 1; end
        end
      end
      default: begin
        m_push(0, 0); nv = 1; mrem--;
        if (mrem == 0) ms = M_READY;
      end
    endcase
    ev = d2v;
    if (ev) begin lastRe = d2re; lastIm = d2im; end
    d2v = d1v; d2re = d1re; d2im = d1im;
    d1v = nv;  d1re = nre;  d1im = nim;

    check("dataOutValid", bus.dataOutValid, ev);
    check("dataOutRe",    bus.dataOutRe,    lastRe);
    check("dataOutIm",    bus.dataOutIm,    lastIm);
    check("coeffReady",   bus.coeffReady,   ms == M_LOAD);
    check("coeffSetFlag", bus.coeffSetFlag, ms == M_READY || ms == M_FLUSH);
    check("busy",         bus.busy,         ms == M_LOAD || ms == M_FLUSH);
    if (bus.dataOutValid === 1'b1) begin
      capRe.push_back(bus.dataOutRe);
      capIm.push_back(bus.dataOutIm);
    end
    if (bus.busy === 1'b1) busyCnt++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_taps();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < L; k++) cyc(0, 1, tRe[k], tIm[k], 0, 0, 0, 0);
  endtask

  task automatic cap_clear();
    capRe.delete();
    capIm.delete();
  endtask

  // asynchronous reset pulse in the middle of a cycle
  task automatic do_reset(string tag);
    #2;
    resetN = 1'b0;
    #1;
    check_outputs_zero(tag);
    m_reset();
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;
  endtask

  task automatic impulse_scenario(string tag);
    for (int k = 0; k < L; k++) begin tRe[k] = k + 1; tIm[k] = 0; end
    load_taps();
    cap_clear();
    cyc(0, 0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    idle(L + 4);
    check({tag, ".count"}, capRe.size(), L);
    for (int k = 0; k < L && k < capRe.size(); k++) begin
      check({tag, ".re"}, capRe[k], k + 1);
      check({tag, ".im"}, capIm[k], 0);
    end
  endtask

  initial begin
    resetN = 1'b0;
    bus.loadCoeff = 0; bus.coeffValid = 0; bus.coeffInRe = '0; bus.coeffInIm = '0;
    bus.dataInValid = 0; bus.dataInRe = '0; bus.dataInIm = '0; bus.flush = 0;
    busyCnt = 0;
    m_reset();
    #3;
    check_outputs_zero("reset");
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;

    // data, flush and coefficients are ignored in IDLE
    cyc(0, 1, 5, 5, 1, 3, 3, 1);
    cyc(0, 0, 0, 0, 1, 7, 7, 0);

    // real impulse response through the flush
    impulse_scenario("impulse");

    // complex multiply on a single tap
    for (int k = 0; k < L; k++) begin tRe[k] = 0; tIm[k] = 0; end
    tRe[0] = 1; tIm[0] = 1;
    load_taps();
    cap_clear();
    cyc(0, 0, 0, 0, 1, 2, 3, 0);
    cyc(0, 0, 0, 0, 1, 5, 10, 0);
    idle(4);
    check("cmul.count", capRe.size(), 2);
    if (capRe.size() >= 2) begin
      check("cmul.re0", capRe[0], -1);
      check("cmul.im0", capIm[0], 5);
      check("cmul.re1", capRe[1], -5);
      check("cmul.im1", capIm[1], 15);
    end

    // extreme values: full-length worst-case accumulation
    for (int k = 0; k < L; k++) begin tRe[k] = -128; tIm[k] = -128; end
    load_taps();
    cap_clear();
    for (int i = 0; i < L; i++) cyc(0, 0, 0, 0, 1, -128, -128, 0);
    idle(4);
    check("extreme.count", capRe.size(), L);
    if (capRe.size() >= L) begin
      check("extreme.re", capRe[L-1], 0);
      check("extreme.im", capIm[L-1], 393216);
    end

    // gapped input then flush; data and loadCoeff during FLUSH are ignored
    for (int k = 0; k < L; k++) begin
      tRe[k] = longint'($urandom_range(0, 255)) - 128;
      tIm[k] = longint'($urandom_range(0, 255)) - 128;
    end
    load_taps();
    cap_clear();
    cyc(0, 0, 0, 0, 1, 17, -4, 0);
    idle(1);
    cyc(0, 0, 0, 0, 1, -90, 33, 0);
    idle(2);
    cyc(0, 0, 0, 0, 1, 127, -128, 0);
    busyCnt = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++)
      cyc(i == 4, 0, 0, 0, 1, longint'($urandom_range(0, 255)) - 128, 5, i == 6);
    idle(6);
    check("flush.pulses", capRe.size(), 3 + L - 1);
    check("flush.busy", busyCnt, L - 1);

    // priority: loadCoeff beats data and flush, in-flight results still emerge
    cap_clear();
    cyc(0, 0, 0, 0, 1, 11, 22, 0);
    cyc(0, 0, 0, 0, 1, -33, 44, 0);
    cyc(1, 0, 0, 0, 1, 55, 66, 1);
    check("prio.coeffReady", bus.coeffReady, 1);
    check("prio.busy", bus.busy, 1);
    idle(4);
    check("prio.count", capRe.size(), 2);

    // reset part-way through a load, then the impulse case again
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 1, 9, -9, 0, 0, 0, 0);
    do_reset("midload");
    impulse_scenario("impulse2");

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bit lc, cv, dv, fl;
      lc = $urandom_range(0, 99) < 3;
      cv = (ms == M_LOAD) ? ($urandom_range(0, 99) < 75) : ($urandom_range(0, 99) < 10);
      dv = $urandom_range(0, 99) < 70;
      fl = $urandom_range(0, 99) < 5;
      if (ms == M_IDLE) lc = 1;
      cyc(lc, cv, longint'($urandom_range(0, 255)) - 128, longint'($urandom_range(0, 255)) - 128,
          dv, longint'($urandom_range(0, 255)) - 128, longint'($urandom_range(0, 255)) - 128, fl);
      if (i == 750) do_reset("rand");
    end
    idle(L + 4);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
